// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM states, code geometry,
// and the combination-index to code-bit mapping.
package truth_table_pkg;

  localparam int TT_CODE_W = 8;
  localparam int TT_N_IN   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_ADVANCE,
    ST_DONE
  } tt_state_e;

  // Combination 000 lands in the MSB so the code reads like a case-table literal.
  function automatic logic [TT_N_IN-1:0] tt_bit_index(input logic [TT_N_IN-1:0] k);
    return 3'd7 - k;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_voter.sv
// Sample voter: 2-flop synchronizer on the async DUT output, a ones counter and a
// majority compare. clear zeroes the counter, enable accumulates one sample.
module tt_sample_voter #(
  parameter int SAMPLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic dut_out,
  output logic resolve
);

  localparam int CW = $clog2(SAMPLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      ones    <= '0;
    end else begin
      sync_p0 <= dut_out;
      sync_p1 <= sync_p0;
      if (clear) begin
        ones <= '0;
      end else if (enable) begin
        ones <= ones + CW'(sync_p1);
      end
    end
  end

  assign resolve = (ones > CW'(SAMPLES / 2));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all eight input combinations, majority-votes each
// settled output and reports the resulting truth-table code against an expected one.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [TT_CODE_W-1:0] expected,
  output logic                 in1,
  output logic                 in2,
  output logic                 in3,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [TT_CODE_W-1:0] code,
  output logic                 match,
  output logic [TT_CODE_W-1:0] mismatch_mask
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int MW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  tt_state_e            state, state_nxt;
  logic [SW-1:0]        settle_cnt;
  logic [MW-1:0]        sample_cnt;
  logic [TT_N_IN-1:0]   k;
  logic [TT_CODE_W-1:0] exp_q;
  logic [TT_CODE_W-1:0] acc;
  logic [TT_CODE_W-1:0] acc_nxt;
  logic                 accept;
  logic                 v_clear;
  logic                 v_en;
  logic                 vote;

  tt_sample_voter #(.SAMPLES(SAMPLES)) u_voter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (v_clear),
    .enable  (v_en),
    .dut_out (dut_out),
    .resolve (vote)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    v_clear   = 1'b0;
    v_en      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          v_clear   = 1'b1;
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        v_en = 1'b1;
        if (sample_cnt == '0) state_nxt = ST_ADVANCE;
      end
      ST_ADVANCE: state_nxt = (k == 3'd7) ? ST_DONE : ST_SETTLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_nxt                  = acc;
    acc_nxt[tt_bit_index(k)] = vote;
  end

  // Sweep datapath: counters, combination index, shift-in of voted bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt    <= '0;
      sample_cnt    <= '0;
      k             <= '0;
      exp_q         <= '0;
      acc           <= '0;
      code          <= '0;
      match         <= 1'b0;
      mismatch_mask <= '0;
    end else if (accept) begin
      exp_q      <= expected;
      acc        <= '0;
      k          <= '0;
      settle_cnt <= SW'(SETTLE_CYCLES - 1);
    end else begin
      case (state)
        ST_SETTLE: begin
          if (settle_cnt == '0) sample_cnt <= MW'(SAMPLES - 1);
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        ST_SAMPLE: begin
          if (sample_cnt != '0) sample_cnt <= sample_cnt - 1'b1;
        end
        ST_ADVANCE: begin
          acc <= acc_nxt;
          if (k == 3'd7) begin
            code          <= acc_nxt;
            match         <= (acc_nxt == exp_q);
            mismatch_mask <= acc_nxt ^ exp_q;
          end else begin
            k          <= k + 3'd1;
            settle_cnt <= SW'(SETTLE_CYCLES - 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE) || (state == ST_ADVANCE);
  assign done = (state == ST_DONE);
  assign {in1, in2, in3} = busy ? k : 3'b000;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper against a behavioural 0x84 gate with
// programmable output inversion windows.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] expected;
  logic       in1, in2, in3;
  logic       dut_out;
  logic       busy, done, match;
  logic [7:0] code, mismatch_mask;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  int g_lo = 100000;
  int g_hi = 100000;
  int rel;
  int n_done;
  int n_bad;
  int done_at[$];

  truth_table_sweeper #(.SETTLE_CYCLES(4), .SAMPLES(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .expected      (expected),
    .in1           (in1),
    .in2           (in2),
    .in3           (in3),
    .dut_out       (dut_out),
    .busy          (busy),
    .done          (done),
    .code          (code),
    .match         (match),
    .mismatch_mask (mismatch_mask)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  // Gate under characterization: 1 only at 000 and 101, optionally inverted.
  logic [2:0] idx;
  assign idx = {in1, in2, in3};
  always_comb begin
    dut_out = ((idx == 3'd0) || (idx == 3'd5)) ^
              (((cyc - t0) >= g_lo) && ((cyc - t0) <= g_hi));
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] exp_code);
    step();
    start    = 1'b1;
    expected = exp_code;
    t0       = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int r);
    r = -1;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        r = cyc - t0;
        return;
      end
      step();
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] c, input logic m,
                              input logic [7:0] mm);
    check({tag, "_code"}, 32'(code), 32'(c));
    check({tag, "_match"}, 32'(match), 32'(m));
    check({tag, "_mask"}, 32'(mismatch_mask), 32'(mm));
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    expected = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in", 32'({in1, in2, in3}), 32'd0);
    check_result("rst", 8'h00, 1'b0, 8'h00);
    step();
    rst_n = 1'b1;
    step();

    // Nominal sweep
    launch(8'h84);
    check("nom_busy_c1", 32'(busy), 32'd1);
    wait_done(rel);
    check("nom_done_cycle", 32'(rel), 32'd65);
    check("nom_busy_in_done", 32'(busy), 32'd0);
    check_result("nom", 8'h84, 1'b1, 8'h00);
    step();
    check("nom_done_pulse", 32'(done), 32'd0);

    // Mismatch against 0x85
    launch(8'h85);
    wait_done(rel);
    check_result("mis", 8'h84, 1'b0, 8'h01);

    // Glitch on one of the three k=5 samples is voted away
    g_lo = 43; g_hi = 43;
    launch(8'h84);
    wait_done(rel);
    check_result("glitch1", 8'h84, 1'b1, 8'h00);

    // Glitch on two samples flips the k=5 bit
    g_lo = 43; g_hi = 44;
    launch(8'h84);
    wait_done(rel);
    check_result("glitch2", 8'h80, 1'b0, 8'h04);
    g_lo = 100000; g_hi = 100000;

    // Start while busy is ignored and expected is not recaptured
    launch(8'h84);
    while ((cyc - t0) < 20) step();
    start    = 1'b1;
    expected = 8'h00;
    step();
    start = 1'b0;
    wait_done(rel);
    check("busy_start_cycle", 32'(rel), 32'd65);
    check_result("busy_start", 8'h84, 1'b1, 8'h00);

    // Reset during k=3 aborts the sweep
    launch(8'h84);
    while ((cyc - t0) < 28) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_in", 32'({in1, in2, in3}), 32'd0);
    check_result("mid_rst", 8'h00, 1'b0, 8'h00);
    step();
    rst_n  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (done) n_done++;
    end
    check("mid_rst_no_done", 32'(n_done), 32'd0);
    launch(8'h84);
    wait_done(rel);
    check("post_rst_cycle", 32'(rel), 32'd65);
    check_result("post_rst", 8'h84, 1'b1, 8'h00);

    // Back-to-back sweeps with start held high
    step();
    start    = 1'b1;
    expected = 8'h84;
    t0       = cyc;
    n_bad    = 0;
    for (int i = 1; i <= 196; i++) begin
      step();
      if (done) done_at.push_back(cyc - t0);
      if (!busy && !done) n_bad++;
    end
    start = 1'b0;
    check("b2b_n_done", 32'(done_at.size()), 32'd3);
    if (done_at.size() >= 3) begin
      check("b2b_done0", 32'(done_at[0]), 32'd65);
      check("b2b_done1", 32'(done_at[1]), 32'd130);
      check("b2b_done2", 32'(done_at[2]), 32'd195);
    end
    check("b2b_busy_gaps", 32'(n_bad), 32'd0);
    check("b2b_match", 32'(match), 32'd1);
    wait_done(rel);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential characterizer for 3-input combinational logic gates of the kind specified as case-statement truth tables (e.g. `0x84`). It drives a device under test through all eight input combinations, waits a settle window, and majority-votes the sampled output. It then assembles the 8-bit hex truth-table code and compares it against an expected code. It sits on the test/characterization side of the gate library, as the reader of what each gate module writes.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 4: cycles each input combination is held before sampling starts. Must be ≥ 2, because `dut_out` passes through an internal 2-flop synchronizer.
- `SAMPLES`, default 3: samples taken per combination. Must be odd and ≥ 1.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a sweep. Sampled only when `busy`=0.
- `expected`, input, 8: expected truth-table code. Captured on an accepted `start`.
- `in1`, `in2`, `in3`, output, 1 each: stimulus to the DUT. `in1` is the MSB of the combination index.
- `dut_out`, input, 1: DUT output. Treated as asynchronous.
- `busy`, output, 1: high while a sweep is in progress.
- `done`, output, 1: one-cycle pulse when `code`, `match` and `mismatch_mask` become valid.
- `code`, output, 8: measured truth-table code.
- `match`, output, 1: 1 when `code` == captured `expected`.
- `mismatch_mask`, output, 8: `code` XOR captured `expected`.

## Operation

Code bit mapping:
- For combination index k = {in1,in2,in3}, the result goes to `code[7-k]`.
- So 000 maps to bit 7 and 111 maps to bit 0.
- Example: a gate that is 1 only at 000 and 101 yields 0x84.

FSM states are IDLE, SETTLE, SAMPLE, ADVANCE and DONE.
- **IDLE:** `in1..3`=000 and `busy`=0. On `start`=1:
  - capture `expected`;
  - clear the code shift register;
  - set k=0, load the settle counter with `SETTLE_CYCLES`-1;
  - go to SETTLE.
- **SETTLE:** drive k on `in1..3` and decrement the counter. At 0, clear the ones counter, load the sample counter with `SAMPLES`-1 and go to SAMPLE.
- **SAMPLE:** each cycle, add the synchronized `dut_out` to the ones counter (width clog2(`SAMPLES`+1)). When the sample counter reaches 0, go to ADVANCE.
- **ADVANCE:** one cycle.
  - Resolve the bit as 1 if ones > `SAMPLES`/2, and write it to `code[7-k]`.
  - If k=7, go to DONE.
  - Otherwise increment k, reload the settle counter and go to SETTLE.
- **DONE:** one cycle.
  - Update `code`, `match` and `mismatch_mask`; pulse `done`=1; drive `busy`=0.
  - Return to IDLE.
  - A `start` in this cycle is accepted, exactly as in IDLE.

General rules:
- `start` while `busy`=1 is ignored. It is not queued.
- `code`, `match` and `mismatch_mask` hold their values until the next DONE. They do not change mid-sweep; intermediate bits live in an internal register.
- `expected` is sampled only on acceptance. Later changes have no effect on the running sweep.

## Timing

Reset values, applied asynchronously and immediately:
- FSM=IDLE.
- `in1..3`=000, `busy`=0, `done`=0, `code`=0x00, `match`=0, `mismatch_mask`=0x00.
- All counters and synchronizer flops cleared.

Reset mid-sweep aborts the sweep with no `done` pulse. A fresh `start` after reset release runs a full sweep.

Cycle numbering, with `start` accepted at cycle 0:
- `busy` rises at cycle 1.
- Combination k is driven from cycle 1 + k·(S+M+1), where S=`SETTLE_CYCLES` and M=`SAMPLES`.
- `done` pulses at cycle 8·(S+M+1)+1. With the defaults (S=4, M=3) this is cycle 65.
- `busy` is 0 in the `done` cycle.

Synchronizer latency:
- The synchronizer adds 2 cycles.
- The DUT output therefore has S−2 cycles of real settle margin before the first sample.

## Structure

- Package `truth_table_pkg` holds:
  - the FSM state enum;
  - `TT_CODE_W`=8 and `TT_N_IN`=3;
  - the function `tt_bit_index(k)` = 7−k.
- Sub-module `tt_sample_voter` contains the 2-flop synchronizer, the ones counter and the majority compare. It has a clear/enable/resolve interface.
- The top level contains the FSM, the settle counter, k, and the code/compare registers.

## Test plan

- **Nominal sweep:** behavioural DUT = 0x84 function, S=4, M=3, `expected`=0x84 → `done` at cycle 65, `code`=0x84, `match`=1, `mismatch_mask`=0x00.
- **Mismatch:** same DUT, `expected`=0x85 → `code`=0x84, `match`=0, `mismatch_mask`=0x01.
- **Glitch rejection:** DUT output inverted for exactly 1 of the 3 sample cycles at k=5 → `code` is still 0x84. When inverted for 2 of 3 samples → `code`=0x80.
- **Start while busy:** pulse `start` with `expected`=0x00 at cycle 20 → ignored; `done` still at cycle 65 with the original `expected` (0x84) and `match`=1.
- **Reset mid-sweep:** assert `rst_n`=0 during k=3 → all outputs at reset values immediately and no `done`; a new `start` yields `code`=0x84 after 65 cycles.
- **Back-to-back sweeps:** `start` held high continuously → `done` pulses every 65 cycles, and `busy` is low only in each `done` cycle.
